otter_fetch_stage: RTL and testbench

- Pipeline instruction-fetch stage plus IF/ID register for the pipelined OTTER RV32I core.
- Owns the PC and runs a single-outstanding request/acknowledge handshake to instruction memory.
- Presents {IR, PC, PC+4, valid} to the decode stage, which produces ALU/PC_SOURCE/RF controls.
- Accepts a stall from the hazard unit and a redirect (taken branch/JAL/JALR target) from execute.

---
 rtl/otter_fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_otter_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_stage.sv
// Instruction-fetch stage and IF/ID register for the pipelined OTTER RV32I core.
// Single-outstanding request/acknowledge fetch with a one-entry skid buffer for stalls.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        IFID_VALID,
    output logic [31:0] IFID_IR,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_BUFFERED = 2'd2,
        S_DISCARD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] skid_ir_q, skid_ir_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_ir_q, ifid_ir_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = {REDIRECT_PC[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        skid_ir_d    = skid_ir_q;
        skid_pc_d    = skid_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_ir_d    = ifid_ir_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;

        if (REDIRECT) begin
            ifid_valid_d = 1'b0;
            ifid_ir_d    = NOP_INSTR;
            skid_ir_d    = NOP_INSTR;
            skid_pc_d    = 32'd0;
            unique case (state_q)
                S_FETCH: begin
                    if (IMEM_ACK) begin
                        pc_d = redirect_target;
                    end else begin
                        // The request in flight must complete before the new target is fetched.
                        redir_d = redirect_target;
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (IMEM_ACK) begin
                        pc_d    = redirect_target;
                        state_d = S_FETCH;
                    end else begin
                        redir_d = redirect_target;
                    end
                end
                default: begin
                    pc_d    = redirect_target;
                    state_d = S_FETCH;
                end
            endcase
        end else begin
            // Decode consumed the current entry; it becomes a bubble unless replaced below.
            if (!STALL) begin
                ifid_valid_d = 1'b0;
                ifid_ir_d    = NOP_INSTR;
            end
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (IMEM_ACK) begin
                        pc_d = pc_plus4;
                        if (STALL) begin
                            skid_ir_d = IMEM_RDATA;
                            skid_pc_d = pc_q;
                            state_d   = S_BUFFERED;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_ir_d    = IMEM_RDATA;
                            ifid_pc_d    = pc_q;
                            ifid_pc4_d   = pc_plus4;
                        end
                    end
                end
                S_BUFFERED: begin
                    if (!STALL) begin
                        ifid_valid_d = 1'b1;
                        ifid_ir_d    = skid_ir_q;
                        ifid_pc_d    = skid_pc_q;
                        ifid_pc4_d   = skid_pc_q + 32'd4;
                        skid_ir_d    = NOP_INSTR;
                        skid_pc_d    = 32'd0;
                        state_d      = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (IMEM_ACK) begin
                        pc_d    = redir_q;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            redir_q      <= 32'd0;
            skid_ir_q    <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_ir_q    <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_q      <= redir_d;
            skid_ir_q    <= skid_ir_d;
            skid_pc_q    <= skid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // The address is the PC register itself, so it cannot move while a request waits.
    assign IMEM_REQ   = (state_q == S_FETCH) || (state_q == S_DISCARD);
    assign IMEM_ADDR  = pc_q;
    assign IFID_VALID = ifid_valid_q;
    assign IFID_IR    = ifid_ir_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_PC4   = ifid_pc4_q;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed and randomized checks of otter_fetch_stage against a program-order scoreboard.
module tb_otter_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_ir;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

    int tests_run;
    int tests_failed;
    bit verbose;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    otter_fetch_stage u_dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .STALL       (stall),
        .REDIRECT    (redirect),
        .REDIRECT_PC (redirect_pc),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .IMEM_ACK    (imem_ack),
        .IMEM_RDATA  (imem_rdata),
        .IFID_VALID  (ifid_valid),
        .IFID_IR     (ifid_ir),
        .IFID_PC     (ifid_pc),
        .IFID_PC4    (ifid_pc4)
    );

    otter_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK         (clk),
        .RST_N       (rst_n),
        .STALL       (1'b0),
        .REDIRECT    (1'b0),
        .REDIRECT_PC (32'd0),
        .IMEM_REQ    (w_req),
        .IMEM_ADDR   (w_addr),
        .IMEM_ACK    (1'b1),
        .IMEM_RDATA  (w_rdata),
        .IFID_VALID  (w_valid),
        .IFID_IR     (w_ir),
        .IFID_PC     (w_pc),
        .IFID_PC4    (w_pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (verbose) $display("[TB] %-16s observed %h expected %h", tag, obs, exp);
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},   32'd0);
        check({tag, "_addr"},  imem_addr,           32'd0);
        check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, "_ir"},    ifid_ir,             NOP);
        check({tag, "_pc"},    ifid_pc,             32'd0);
        check({tag, "_pc4"},   ifid_pc4,            32'd0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        prev_req;
        logic [31:0] prev_addr;
        logic        prev_valid;
        logic [31:0] prev_ir, prev_pc, prev_pc4;
        logic        s_i, a_i, r_i;
        logic [31:0] t_i;
        int          delivered;

        tests_run    = 0;
        tests_failed = 0;
        verbose      = 1'b1;
        rst_n        = 1'b0;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        imem_ack     = 1'b1;

        // Reset state, then release and stream with ACK tied high.
        repeat (2) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        check("req_pre_edge1", {31'd0, imem_req}, 32'd0);
        step();
        check("req_edge1",   {31'd0, imem_req}, 32'd1);
        check("addr_edge1",  imem_addr, 32'h0);
        check("wrap_addr0",  w_addr, 32'hFFFF_FFFC);
        step();
        check("ifid_pc_0",   ifid_pc, 32'h0);
        check("ifid_pc4_0",  ifid_pc4, 32'h4);
        check("ifid_ir_0",   ifid_ir, mem_word(32'h0));
        check("ifid_val_0",  {31'd0, ifid_valid}, 32'd1);
        check("wrap_pc",     w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4",    w_pc4, 32'h0);
        check("wrap_addr1",  w_addr, 32'h0);
        step();
        check("ifid_pc_4",   ifid_pc, 32'h4);
        step();
        check("ifid_pc_8",   ifid_pc, 32'h8);
        check("ifid_pc4_8",  ifid_pc4, 32'hC);
        step();
        check("addr_10",     imem_addr, 32'h10);

        // ACK at 0x10 under a three-cycle stall lands in the skid buffer.
        stall = 1'b1;
        step();
        check("stall_req0",  {31'd0, imem_req}, 32'd0);
        check("stall_hold",  ifid_pc, 32'hC);
        step();
        check("stall_req1",  {31'd0, imem_req}, 32'd0);
        step();
        check("stall_hold2", ifid_pc, 32'hC);
        stall = 1'b0;
        step();
        check("skid_pc",     ifid_pc, 32'h10);
        check("skid_ir",     ifid_ir, mem_word(32'h10));
        check("skid_val",    {31'd0, ifid_valid}, 32'd1);
        check("skid_addr",   imem_addr, 32'h14);
        step();
        check("after_skid",  ifid_pc, 32'h14);

        // Redirect with no ACK: the old request completes, then fetch resumes at the target.
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        check("disc_req",    {31'd0, imem_req}, 32'd1);
        check("disc_addr",   imem_addr, 32'h18);
        check("disc_val",    {31'd0, ifid_valid}, 32'd0);
        check("disc_ir",     ifid_ir, NOP);
        step();
        check("disc_addr2",  imem_addr, 32'h18);
        check("disc_val2",   {31'd0, ifid_valid}, 32'd0);
        imem_ack = 1'b1;
        step();
        check("redir_addr",  imem_addr, 32'h100);
        check("redir_val",   {31'd0, ifid_valid}, 32'd0);
        step();
        check("redir_pc",    ifid_pc, 32'h100);
        check("redir_ir",    ifid_ir, mem_word(32'h100));

        // Redirect coincident with ACK and STALL.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        check("co_val",      {31'd0, ifid_valid}, 32'd0);
        check("co_ir",       ifid_ir, NOP);
        check("co_addr",     imem_addr, 32'h200);
        check("co_req",      {31'd0, imem_req}, 32'd1);
        step();
        check("co_next_pc",  ifid_pc, 32'h200);
        check("co_next_val", {31'd0, ifid_valid}, 32'd1);

        // Asynchronous reset in the middle of DISCARD.
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");

        // Randomized traffic against a program-order scoreboard.
        verbose = 1'b0;
        step();
        rst_n     = 1'b1;
        exp_pc    = 32'h0;
        delivered = 0;
        for (int i = 0; i < 2000; i++) begin
            s_i = ($urandom_range(0, 3) == 0);
            a_i = ($urandom_range(0, 2) != 0);
            r_i = ($urandom_range(0, 15) == 0);
            t_i = $urandom;
            stall       = s_i;
            imem_ack    = a_i;
            redirect    = r_i;
            redirect_pc = t_i;
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_valid = ifid_valid;
            prev_ir    = ifid_ir;
            prev_pc    = ifid_pc;
            prev_pc4   = ifid_pc4;
            step();
            if (prev_req && !a_i) begin
                check("rnd_req_held",  {31'd0, imem_req}, 32'd1);
                check("rnd_addr_held", imem_addr, prev_addr);
            end
            if (r_i) begin
                check("rnd_flush_val", {31'd0, ifid_valid}, 32'd0);
                check("rnd_flush_ir",  ifid_ir, NOP);
                exp_pc = {t_i[31:2], 2'b00};
            end else if (s_i) begin
                check("rnd_stall_val", {31'd0, ifid_valid}, {31'd0, prev_valid});
                check("rnd_stall_ir",  ifid_ir, prev_ir);
                check("rnd_stall_pc",  ifid_pc, prev_pc);
                check("rnd_stall_pc4", ifid_pc4, prev_pc4);
            end else if (ifid_valid) begin
                check("rnd_pc",  ifid_pc, exp_pc);
                check("rnd_ir",  ifid_ir, mem_word(exp_pc));
                check("rnd_pc4", ifid_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                check("rnd_bubble_ir", ifid_ir, NOP);
            end
        end
        $display("[TB] random phase delivered %0d instructions", delivered);
        check("rnd_progress", {31'd0, (delivered > 100)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
